// File: rtl/burst_xfer_ctrl.sv
// burst_xfer_ctrl: moves a programmed number of beats between the APB
// register bank and the burst interface, split into bursts of at most
// max_burst_size beats. Write mode fetches each beat from the register bank
// and sends it on the burst write channel; read mode accepts beats from the
// burst read channel and writes them into the register bank.
// Every output comes straight from a flop, so it trails the state by one cycle.
// Optional feature macro: BURST_XFER_TIMEOUT_EN (stall timeout of TIMEOUT_CYC cycles).
module burst_xfer_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 9,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rb_db_start,
    input  logic              rb_db_rw,
    input  logic [ADDR_W-1:0] rb_db_base_addr,
    input  logic [LEN_W-1:0]  rb_db_length,
    input  logic [LEN_W-1:0]  rb_db_max_burst_size,
    input  logic [DATA_W-1:0] rb_db_data,
    input  logic              rb_db_ack,
    output logic              db_rb_req,
    output logic              db_rb_we,
    output logic [ADDR_W-1:0] db_rb_addr,
    output logic [DATA_W-1:0] db_rb_data,
    output logic              db_rb_idle,
    output logic              db_rb_done,
    output logic              db_rb_err,
    output logic              db_valid,
    output logic [DATA_W-1:0] db_data,
    output logic              db_last,
    input  logic              burst_ready,
    input  logic              burst_valid,
    input  logic [DATA_W-1:0] burst_data_in,
    input  logic              burst_last,
    output logic              db_ready
);

    typedef enum logic [2:0] {
        IDLE, CONFIG, FETCH, WAIT_ACK, SEND, RECV, DONE
    } state_t;

    state_t state_q, state_d;

    // Transfer configuration captured with the start pulse
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  max_q, max_d;

    // Running transfer position
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  beat_q, beat_d;

    // Output flops
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
    logic [DATA_W-1:0] rb_data_q, rb_data_d;
    logic              idle_q, idle_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;

    logic              is_last;
    logic [LEN_W-1:0]  beat_nxt;
    logic              send_hs;
    logic              recv_hs;
    logic              timeout;

    // A beat closes a burst when it fills the burst or ends the transfer;
    // max_burst_size of 0 means the whole transfer is one burst.
    assign is_last  = (rem_q == LEN_W'(1)) ||
                      ((max_q != '0) && (beat_q == max_q - LEN_W'(1)));
    assign beat_nxt = is_last ? '0 : beat_q + LEN_W'(1);
    assign send_hs  = (state_q == SEND) && valid_q && burst_ready;
    assign recv_hs  = (state_q == RECV) && ready_q && burst_valid;

`ifdef BURST_XFER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC) + 1;

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stalled;

    // Consecutive stall cycles in any state waiting on the far side
    always_comb begin
        stalled = ((state_q == SEND)     && !burst_ready) ||
                  ((state_q == RECV)     && !burst_valid) ||
                  ((state_q == WAIT_ACK) && !rb_db_ack);
        stall_d = stalled ? stall_q + STALL_W'(1) : '0;
        timeout = stalled && (stall_q == STALL_W'(TIMEOUT_CYC - 1));
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`else
    // Without the timeout a stall simply waits; the parameter stays in the
    // port list so both builds share one instantiation.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rb_db_start) state_d = CONFIG;
            CONFIG: begin
                if (len_q == '0) state_d = DONE;
                else if (rw_q)   state_d = FETCH;
                else             state_d = RECV;
            end
            FETCH:    state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (rb_db_ack)    state_d = SEND;
                else if (timeout) state_d = DONE;
            end
            SEND: begin
                if (send_hs)      state_d = (rem_q == LEN_W'(1)) ? DONE : FETCH;
                else if (timeout) state_d = DONE;
            end
            RECV: begin
                if (recv_hs)      state_d = (rem_q == LEN_W'(1)) ? DONE : RECV;
                else if (timeout) state_d = DONE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        rw_d      = rw_q;
        base_d    = base_q;
        len_d     = len_q;
        max_d     = max_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beat_d    = beat_q;
        req_d     = 1'b0;
        we_d      = 1'b0;
        rb_addr_d = rb_addr_q;
        rb_data_d = rb_data_q;
        idle_d    = (state_q == IDLE);
        done_d    = 1'b0;
        err_d     = err_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rb_db_start) begin
                    rw_d   = rb_db_rw;
                    base_d = rb_db_base_addr;
                    len_d  = rb_db_length;
                    max_d  = rb_db_max_burst_size;
                end
            end
            CONFIG: begin
                rem_d  = len_q;
                addr_d = base_q;
                beat_d = '0;
                err_d  = (len_q == '0);
            end
            FETCH: begin
                req_d     = 1'b1;
                rb_addr_d = addr_q;
            end
            WAIT_ACK: begin
                if (rb_db_ack) begin
                    data_d  = rb_db_data;
                    valid_d = 1'b1;
                    last_d  = is_last;
                end else if (timeout) begin
                    err_d = 1'b1;
                end
            end
            SEND: begin
                if (send_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    rem_d   = rem_q - LEN_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    beat_d  = beat_nxt;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            RECV: begin
                if (recv_hs) begin
                    req_d     = 1'b1;
                    we_d      = 1'b1;
                    rb_addr_d = addr_q;
                    rb_data_d = burst_data_in;
                    // Sender's framing must match ours; flag and keep going
                    if (burst_last != is_last) err_d = 1'b1;
                    rem_d     = rem_q - LEN_W'(1);
                    addr_d    = addr_q + ADDR_W'(1);
                    beat_d    = beat_nxt;
                    // Drop ready right after the final beat so no extra is taken
                    ready_d   = (rem_q != LEN_W'(1));
                end else if (timeout) begin
                    err_d = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_q      <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            max_q     <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            beat_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            rb_addr_q <= '0;
            rb_data_q <= '0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            rw_q      <= rw_d;
            base_q    <= base_d;
            len_q     <= len_d;
            max_q     <= max_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beat_q    <= beat_d;
            req_q     <= req_d;
            we_q      <= we_d;
            rb_addr_q <= rb_addr_d;
            rb_data_q <= rb_data_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
        end
    end

    assign db_rb_req  = req_q;
    assign db_rb_we   = we_q;
    assign db_rb_addr = rb_addr_q;
    assign db_rb_data = rb_data_q;
    assign db_rb_idle = idle_q;
    assign db_rb_done = done_q;
    assign db_rb_err  = err_q;
    assign db_valid   = valid_q;
    assign db_data    = data_q;
    assign db_last    = last_q;
    assign db_ready   = ready_q;

endmodule

// File: tb/tb_burst_xfer_ctrl.sv
// Directed bench for burst_xfer_ctrl: a register-bank responder that acks
// reads one cycle after the request, a burst stream source, and event logs
// checked against hand-computed expectations.
module tb_burst_xfer_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 8;
    localparam int TO_CYC = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rb_db_start;
    logic              rb_db_rw;
    logic [ADDR_W-1:0] rb_db_base_addr;
    logic [LEN_W-1:0]  rb_db_length;
    logic [LEN_W-1:0]  rb_db_max_burst_size;
    logic [DATA_W-1:0] rb_db_data;
    logic              rb_db_ack;
    logic              db_rb_req;
    logic              db_rb_we;
    logic [ADDR_W-1:0] db_rb_addr;
    logic [DATA_W-1:0] db_rb_data;
    logic              db_rb_idle;
    logic              db_rb_done;
    logic              db_rb_err;
    logic              db_valid;
    logic [DATA_W-1:0] db_data;
    logic              db_last;
    logic              burst_ready;
    logic              burst_valid;
    logic [DATA_W-1:0] burst_data_in;
    logic              burst_last;
    logic              db_ready;

    always #5 clk = ~clk;

    burst_xfer_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rb_db_start(rb_db_start), .rb_db_rw(rb_db_rw),
        .rb_db_base_addr(rb_db_base_addr), .rb_db_length(rb_db_length),
        .rb_db_max_burst_size(rb_db_max_burst_size),
        .rb_db_data(rb_db_data), .rb_db_ack(rb_db_ack),
        .db_rb_req(db_rb_req), .db_rb_we(db_rb_we),
        .db_rb_addr(db_rb_addr), .db_rb_data(db_rb_data),
        .db_rb_idle(db_rb_idle), .db_rb_done(db_rb_done), .db_rb_err(db_rb_err),
        .db_valid(db_valid), .db_data(db_data), .db_last(db_last),
        .burst_ready(burst_ready),
        .burst_valid(burst_valid), .burst_data_in(burst_data_in), .burst_last(burst_last),
        .db_ready(db_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Event logs filled by the responder
    logic [ADDR_W-1:0] rd_a[$];
    int                rd_c[$];
    logic [ADDR_W-1:0] wr_a[$];
    logic [DATA_W-1:0] wr_d[$];
    int                wr_c[$];
    logic [DATA_W-1:0] tx_d[$];
    logic              tx_l[$];
    logic [DATA_W-1:0] st_d[$];
    logic              st_l[$];
    int   cyc = 0;
    int   done_cnt, valid_cyc, ready_cyc, req_cnt;
    logic err_at_done;

    logic              ack_n;
    logic [ADDR_W-1:0] ack_a;
    logic              pop_n;

    // Register bank contents as seen by the bench
    function automatic logic [DATA_W-1:0] memv(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
        tx_d.delete(); tx_l.delete();
        done_cnt = 0; valid_cyc = 0; ready_cyc = 0; req_cnt = 0; err_at_done = 1'b0;
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic l);
        st_d.push_back(d);
        st_l.push_back(l);
    endtask

    // Pulse start for one edge; c0 is the cycle stamp at the sampling edge
    task automatic start_xfer(input logic rw, input logic [ADDR_W-1:0] base,
                              input logic [LEN_W-1:0] len, input logic [LEN_W-1:0] mx,
                              output int c0);
        @(posedge clk); #1;
        rb_db_rw = rw; rb_db_base_addr = base; rb_db_length = len;
        rb_db_max_burst_size = mx; rb_db_start = 1'b1;
        @(posedge clk);
        c0 = cyc;
        #1 rb_db_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = db_rb_done;
        end
        chk(tag, seen, 1);
    endtask

    // Register-bank responder, burst stream source and event logger
    initial begin
        rb_db_ack = 1'b0; rb_db_data = '0;
        burst_valid = 1'b0; burst_data_in = '0; burst_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            ack_n = db_rb_req && !db_rb_we;
            ack_a = db_rb_addr;
            pop_n = burst_valid && db_ready;
            if (db_rb_req) req_cnt++;
            if (db_rb_req && !db_rb_we) begin rd_a.push_back(db_rb_addr); rd_c.push_back(cyc); end
            if (db_rb_req && db_rb_we) begin
                wr_a.push_back(db_rb_addr); wr_d.push_back(db_rb_data); wr_c.push_back(cyc);
            end
            if (db_valid) valid_cyc++;
            if (db_valid && burst_ready) begin tx_d.push_back(db_data); tx_l.push_back(db_last); end
            if (db_ready) ready_cyc++;
            if (db_rb_done) begin done_cnt++; err_at_done = db_rb_err; end
            @(posedge clk); #1;
            rb_db_ack  = ack_n;
            rb_db_data = ack_n ? memv(ack_a) : '0;
            if (pop_n && st_d.size() > 0) begin void'(st_d.pop_front()); void'(st_l.pop_front()); end
            if (st_d.size() > 0) begin
                burst_valid = 1'b1; burst_data_in = st_d[0]; burst_last = st_l[0];
            end else begin
                burst_valid = 1'b0; burst_data_in = '0; burst_last = 1'b0;
            end
        end
    end

    logic exp_last[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int c0, n;
        logic seen;
        rst_n = 1'b0; rb_db_start = 1'b0; rb_db_rw = 1'b0; rb_db_base_addr = '0;
        rb_db_length = '0; rb_db_max_burst_size = '0; burst_ready = 1'b0;
        clear_logs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", db_rb_idle, 1);
        chk("rst_ctrl", {db_rb_req, db_rb_we, db_rb_done, db_rb_err, db_valid, db_last, db_ready}, 0);
        chk("rst_bus", {db_rb_addr, db_rb_data, db_data}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Read, length 4, one burst, valid every cycle; a spare fifth beat must stay unaccepted
        clear_logs();
        for (int i = 0; i < 5; i++) push_beat(8'hC0 + 8'(i), (i == 3));
        start_xfer(1'b0, 9'h000, 8'd4, 8'd4, c0);
        wait_done("rd4_done_seen", 40, n);
        repeat (3) @(negedge clk);
        chk("rd4_nwr", wr_a.size(), 4);
        for (int i = 0; i < 4; i++) if (i < wr_a.size()) begin
            chk($sformatf("rd4_addr%0d", i), wr_a[i], i);
            chk($sformatf("rd4_data%0d", i), wr_d[i], 8'hC0 + 8'(i));
        end
        if (wr_c.size() > 0) chk("rd4_first_lat", wr_c[0] - c0, 4);
        for (int i = 1; i < 4; i++) if (i < wr_c.size()) chk($sformatf("rd4_gap%0d", i), wr_c[i] - wr_c[i-1], 1);
        chk("rd4_leftover", st_d.size(), 1);
        chk("rd4_ready_low", db_ready, 0);
        chk("rd4_done_cnt", done_cnt, 1);
        chk("rd4_err", err_at_done, 0);
        chk("rd4_idle", db_rb_idle, 1);
        st_d.delete(); st_l.delete();

        // Read, length 3, bursts of 2, sender omits last on beat 2
        clear_logs();
        push_beat(8'h31, 1'b0); push_beat(8'h32, 1'b0); push_beat(8'h33, 1'b1);
        start_xfer(1'b0, 9'h020, 8'd3, 8'd2, c0);
        wait_done("rd3_done_seen", 40, n);
        repeat (3) @(negedge clk);
        chk("rd3_nwr", wr_a.size(), 3);
        for (int i = 0; i < 3; i++) if (i < wr_a.size()) begin
            chk($sformatf("rd3_addr%0d", i), wr_a[i], 9'h020 + 9'(i));
            chk($sformatf("rd3_data%0d", i), wr_d[i], 8'h31 + 8'(i));
        end
        chk("rd3_err_at_done", err_at_done, 1);
        chk("rd3_err_sticky", db_rb_err, 1);
        chk("rd3_done_cnt", done_cnt, 1);

        // Write, length 5, bursts of 2, base 0x10, ready always high
        clear_logs();
        burst_ready = 1'b1;
        start_xfer(1'b1, 9'h010, 8'd5, 8'd2, c0);
        wait_done("wr5_done_seen", 100, n);
        repeat (3) @(negedge clk);
        chk("wr5_nrd", rd_a.size(), 5);
        chk("wr5_ntx", tx_d.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rd_a.size()) chk($sformatf("wr5_addr%0d", i), rd_a[i], 9'h010 + 9'(i));
            if (i < tx_d.size()) begin
                chk($sformatf("wr5_data%0d", i), tx_d[i], memv(9'h010 + 9'(i)));
                chk($sformatf("wr5_last%0d", i), tx_l[i], exp_last[i]);
            end
        end
        if (rd_c.size() > 0) chk("wr5_first_lat", rd_c[0] - c0, 3);
        chk("wr5_done_cnt", done_cnt, 1);
        chk("wr5_err_cleared", err_at_done, 0);

        // Zero length: error, done two cycles after start, no traffic
        clear_logs();
        start_xfer(1'b1, 9'h055, 8'd0, 8'd3, c0);
        wait_done("len0_done_seen", 10, n);
        chk("len0_done_lat", n, 3);
        chk("len0_err", db_rb_err, 1);
        chk("len0_idle_at_done", db_rb_idle, 0);
        @(negedge clk);
        chk("len0_idle_after", db_rb_idle, 1);
        repeat (3) @(negedge clk);
        chk("len0_traffic", req_cnt + valid_cyc + ready_cyc, 0);
        chk("len0_done_cnt", done_cnt, 1);

        // Write across the address wrap, reset while the second beat is in SEND
        clear_logs();
        burst_ready = 1'b1;
        start_xfer(1'b1, 9'h1FF, 8'd2, 8'd0, c0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = db_rb_req && !db_rb_we && (db_rb_addr == 9'h000);
        end
        chk("wrap_req2_seen", seen, 1);
        @(posedge clk); #1 burst_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = db_valid;
        end
        chk("wrap_send2_seen", seen, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_idle", db_rb_idle, 1);
        chk("mrst_ctrl", {db_rb_req, db_rb_we, db_rb_done, db_rb_err, db_valid, db_last, db_ready}, 0);
        chk("mrst_bus", {db_rb_addr, db_rb_data, db_data}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mrst_no_done", done_cnt, 0);
        chk("wrap_nrd", rd_a.size(), 2);
        if (rd_a.size() > 1) begin
            chk("wrap_addr0", rd_a[0], 9'h1FF);
            chk("wrap_addr1", rd_a[1], 9'h000);
        end
        chk("wrap_ntx", tx_d.size(), 1);
        if (tx_d.size() > 0) begin
            chk("wrap_data0", tx_d[0], 8'hA5);
            chk("wrap_last0", tx_l[0], 0);
        end

`ifdef BURST_XFER_TIMEOUT_EN
        // Write stuck in SEND: timeout after TO_CYC stall cycles
        clear_logs();
        burst_ready = 1'b0;
        start_xfer(1'b1, 9'h030, 8'd1, 8'd0, c0);
        wait_done("to_done_seen", 60, n);
        repeat (3) @(negedge clk);
        chk("to_valid_cycles", valid_cyc, TO_CYC);
        chk("to_err", err_at_done, 1);
        chk("to_done_cnt", done_cnt, 1);
        chk("to_ntx", tx_d.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_xfer_ctrl.md
# burst_xfer_ctrl

Parametrised second-generation data/burst controller for the APB-to-burst bridge. Sits between the APB register bank and the burst interface. Moves a programmed number of beats either from the register bank out onto the burst interface (write mode) or from the burst interface into the register bank (read mode). Splits transfers into bursts of at most a programmed size, with a programmable base address, full valid/ready handshaking and protocol-error reporting.

## Interface
- DATA_W, 8, data width of register bank and burst beats
- ADDR_W, 9, register bank address width
- LEN_W, 8, width of length and burst-size fields
- TIMEOUT_CYC, 256, stall limit in cycles (used only with BURST_XFER_TIMEOUT_EN)

Ports:
- clk  in  1  global clock
- rst_n  in  1  reset, synchronous, active-low
- rb_db_start  in  1  start pulse, sampled only in IDLE
- rb_db_rw  in  1  1 = write (RB→burst), 0 = read (burst→RB); sampled in IDLE with start
- rb_db_base_addr  in  ADDR_W  first RB address; sampled with start
- rb_db_length  in  LEN_W  total beats; sampled with start
- rb_db_max_burst_size  in  LEN_W  beats per burst, 0 = single burst; sampled with start
- rb_db_data  in  DATA_W  RB read data, valid with rb_db_ack
- rb_db_ack  in  1  RB read-data acknowledge
- db_rb_req  out  1  RB access request, one-cycle pulse
- db_rb_we  out  1  qualifies db_rb_req as an RB write
- db_rb_addr  out  ADDR_W  RB address
- db_rb_data  out  DATA_W  RB write data
- db_rb_idle  out  1  high in IDLE
- db_rb_done  out  1  one-cycle pulse at end of transfer
- db_rb_err  out  1  sticky error, cleared by next accepted start
- db_valid, db_data[DATA_W], db_last  out  burst write channel
- burst_ready  in  1  burst write channel ready
- burst_valid, burst_data_in[DATA_W], burst_last  in  burst read channel
- db_ready  out  1  burst read channel ready

## Operation
- All outputs are driven from flops.
- States: IDLE, CONFIG, FETCH, WAIT_ACK, SEND, RECV, DONE.
- IDLE → CONFIG on rb_db_start. Start is ignored in every other state.
- CONFIG: latch the sampled fields and set remaining = length, beat_cnt = 0, addr = base_addr, err = 0.
  - length == 0: set err and go to DONE.
  - rw = 1: go to FETCH.
  - rw = 0: go to RECV.
- FETCH: db_rb_req = 1, db_rb_we = 0, db_rb_addr = addr for one cycle, then WAIT_ACK.
- WAIT_ACK: on rb_db_ack, capture rb_db_data into db_data and go to SEND.
- SEND: hold db_valid = 1 with db_data and db_last stable until burst_ready. On the handshake, remaining--, addr++, beat_cnt updates; go to DONE if remaining was 1, else FETCH.
- RECV: db_ready = 1. On burst_valid & db_ready:
  - next cycle: db_rb_req = 1, db_rb_we = 1, db_rb_data = burst_data_in, db_rb_addr = addr;
  - addr++, remaining--;
  - go to DONE when remaining was 1.
- Last-beat rule: a beat is last when beat_cnt == max_burst_size-1 or remaining == 1. beat_cnt resets to 0 after a last beat.
  - Write mode: db_last is driven with exactly this rule.
  - Read mode: burst_last must equal this rule on every accepted beat; any mismatch sets db_rb_err and the transfer continues.
- DONE: db_rb_done = 1 for one cycle, then IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. remaining and beat_cnt are LEN_W bits wide. max_burst_size ≥ length behaves as a single burst.

## Timing
- Reset values: db_rb_req = 0, db_rb_we = 0, db_rb_addr = 0, db_rb_data = 0, db_rb_idle = 1, db_rb_done = 0, db_rb_err = 0, db_valid = 0, db_data = 0, db_last = 0, db_ready = 0. State = IDLE.
- rst_n low at any edge, including mid-transfer, forces reset values on that edge. No done pulse is generated.
- Start at edge T: CONFIG at T+1; the first db_rb_req or db_ready is visible after T+2.
- Write beat: at least 3 cycles (FETCH, WAIT_ACK, SEND), plus ack and ready wait cycles.
- Read beats: one per cycle sustained. The RB write occurs exactly 1 cycle after each accepted beat.
- db_ready drops in the cycle after the final accepted beat; no extra beat is accepted.
- rb_db_ack outside WAIT_ACK is ignored.
- db_rb_done asserts 1 cycle after the last handshake (or after CONFIG when length == 0). db_rb_idle rises the following cycle.

## Configuration
- BURST_XFER_TIMEOUT_EN defined:
  - A stall counter counts consecutive cycles in SEND with ~burst_ready, in RECV with ~burst_valid, or in WAIT_ACK with ~rb_db_ack.
  - On reaching TIMEOUT_CYC: set db_rb_err, deassert db_valid and db_ready, go to DONE.
  - The counter clears on any handshake.
- Undefined: no counter exists, stalls wait indefinitely, and TIMEOUT_CYC is unused.

## Test plan
- Write, length = 5, max_burst = 2, base = 0x10, ack after 1 cycle, ready always high -> 5 beats to addresses 0x10–0x14; db_last on beats 2, 4 and 5; one done pulse; err = 0.
- Read, length = 4, max_burst = 4, valid every cycle, burst_last on beat 4 -> 4 RB writes to 0x00–0x03 at 1 cycle each; done pulse; err = 0.
- Read, length = 3, max_burst = 2, burst_last missing on beat 2 -> all 3 RB writes occur; err = 1 at done; err clears on next start.
- length = 0 -> no req, valid or ready; err = 1; done pulse 2 cycles after start.
- Write, base = 0x1FF, length = 2 -> addresses 0x1FF then 0x000. rst_n pulsed low during SEND of the second beat -> all outputs at reset values on the next edge, no done pulse.
- BURST_XFER_TIMEOUT_EN, TIMEOUT_CYC = 8, burst_ready held low in SEND -> err = 1 and DONE after 8 stall cycles, followed by a done pulse.
